pc_increment_by_4: RTL and testbench
====================================

Name: pc_increment_by_4

Overview:
- Program-counter incrementer for the single-cycle RV32 datapath.
- Produces next sequential PC = PC + 4 combinationally on the fetch path.
- Also holds a registered copy of the last increment for pipeline and debug observation.
- The adder core is purpose-built; it does not instantiate the ALU.

Parameters:
XLEN, 32, datapath width in bits.
INCR, 4, increment constant added to pc; must be less than 2^XLEN.
RESET_PC, 32'h0000_0000, reset value of the registered next-PC.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
pc  input  XLEN  current program counter.
en  input  1  capture enable for the registered stage.
result  output  XLEN  combinational pc + INCR.
carry  output  1  combinational carry-out of pc + INCR.
misaligned  output  1  combinational; 1 when pc[1:0] != 2'b00.
result_q  output  XLEN  registered result.
valid_q  output  1  registered; 1 once result_q holds a captured value.
wrap  output  1  wrap flag; see Optional Feature.

Behaviour:
- result = (pc + INCR) mod 2^XLEN.
  - Pure combinational, zero latency, independent of clk, rst_n and en.
  - Must be settled within 1 ns of a pc change in zero-delay simulation.
- carry = bit XLEN of the (XLEN+1)-bit sum {1'b0,pc} + INCR.
  - For INCR=4, carry=1 exactly when pc >= 32'hFFFF_FFFC.
- misaligned = |pc[1:0].
  - Informational only; result is still pc + INCR.
- Registered stage:
  - On posedge clk with en=1: result_q <= result, valid_q <= 1.
  - With en=0: result_q and valid_q hold.
- Reset: rst_n=0 asynchronously forces result_q=RESET_PC and valid_q=0, regardless of clk.
  - Combinational outputs are unaffected by reset and keep tracking pc.
- Reset deassertion is synchronous to clk.
  - First capture occurs on the first posedge after rst_n=1 with en=1.
- Reset asserted mid-operation: registered outputs clear immediately; the next capture follows the rule above.
- Wrap-around: pc=32'hFFFF_FFFC gives result=0, carry=1; pc=32'hFFFF_FFFF gives result=3, carry=1.
- No X propagation: with pc fully known, result, carry and misaligned must be fully known.

Optional Feature:
- Macro: PC_INCR_WRAP_FLAG_EN.
- Defined:
  - wrap is a registered copy of carry, captured under the same en/clk rule as result_q.
  - wrap resets to 0 on rst_n=0.
- Undefined:
  - wrap is tied to constant 0.
  - No wrap register is built.
- All other behaviour is identical in both builds.

Test Plan:
- Random sweep: 100 random 32-bit pc values, 1 ns apart -> result == pc + 4 (mod 2^32) every time; no clock required.
- Boundaries:
  - pc=0 -> result=4, carry=0.
  - pc=32'h7FFF_FFFC -> result=32'h8000_0000, carry=0.
  - pc=32'hFFFF_FFFC -> result=0, carry=1.
  - pc=32'hFFFF_FFFF -> result=3, carry=1.
- Alignment: pc=32'h0000_1002 -> misaligned=1, result=32'h0000_1006; pc=32'h0000_1000 -> misaligned=0.
- Registered path:
  - rst_n=0 -> result_q=0, valid_q=0.
  - Release, pc=32'h100, en=1, one posedge -> result_q=32'h104, valid_q=1.
  - Then en=0, pc=32'h200, posedge -> result_q stays 32'h104.
- Async reset mid-run: with result_q=32'h104, drop rst_n between clock edges -> result_q=0 and valid_q=0 immediately, while result still equals pc+4.
- Macro build:
  - With PC_INCR_WRAP_FLAG_EN, pc=32'hFFFF_FFFC, en=1, posedge -> wrap=1.
  - Next capture at pc=8 -> wrap=0.
  - Without the macro, wrap=0 throughout.

Source files
------------

// File: rtl/pc_increment_by_4.sv
// Program-counter incrementer: combinational pc + INCR on a parallel-prefix adder, plus a registered copy.
// Optional wrap register enabled by defining PC_INCR_WRAP_FLAG_EN; otherwise wrap is tied to 0.
module pc_increment_by_4 #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] INCR     = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic            en,
  output logic [XLEN-1:0] result,
  output logic            carry,
  output logic            misaligned,
  output logic [XLEN-1:0] result_q,
  output logic            valid_q,
  output logic            wrap
);

  localparam int LEVELS = $clog2(XLEN);

  logic [XLEN-1:0] gen_bit;
  logic [XLEN-1:0] prop_bit;
  logic [XLEN-1:0] gen_acc;
  logic [XLEN-1:0] prop_acc;
  logic [XLEN-1:0] gen_prev;
  logic [XLEN-1:0] prop_prev;
  logic [XLEN-1:0] low_fill;
  logic [XLEN-1:0] sum;

  logic [XLEN-1:0] result_reg;
  logic            valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_bit
      assign gen_bit[gi]  = pc[gi] & INCR[gi];
      assign prop_bit[gi] = pc[gi] ^ INCR[gi];
    end
  endgenerate

  // Kogge-Stone prefix: after the last level gen_acc[i] is the carry out of bits [i:0] (carry-in 0).
  always_comb begin
    gen_acc   = gen_bit;
    prop_acc  = prop_bit;
    gen_prev  = '0;
    prop_prev = '0;
    low_fill  = '0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      gen_prev  = gen_acc;
      prop_prev = prop_acc;
      low_fill  = ~({XLEN{1'b1}} << (1 << lvl));
      gen_acc   = gen_prev | (prop_prev & (gen_prev << (1 << lvl)));
      prop_acc  = prop_prev & ((prop_prev << (1 << lvl)) | low_fill);
    end
  end

  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_sum
      if (gi == 0) begin : g_lsb
        assign sum[gi] = prop_bit[gi];
      end else begin : g_upper
        assign sum[gi] = prop_bit[gi] ^ gen_acc[gi-1];
      end
    end
  endgenerate

  assign result     = sum;
  assign carry      = gen_acc[XLEN-1];
  assign misaligned = |pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= RESET_PC;
      valid_reg  <= 1'b0;
    end else if (en) begin
      result_reg <= sum;
      valid_reg  <= 1'b1;
    end
  end

  assign result_q = result_reg;
  assign valid_q  = valid_reg;

`ifdef PC_INCR_WRAP_FLAG_EN
  logic wrap_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_reg <= 1'b0;
    end else if (en) begin
      wrap_reg <= gen_acc[XLEN-1];
    end
  end

  assign wrap = wrap_reg;
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_increment_by_4.sv
// Self-checking bench for pc_increment_by_4: expected values are queued when stimulus is
// driven and popped when the DUT output is sampled.
module tb_pc_increment_by_4;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        en;
  logic [31:0] result;
  logic        carry;
  logic        misaligned;
  logic [31:0] result_q;
  logic        valid_q;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] value;
  } exp_t;

  exp_t sb_q[$];

`ifdef PC_INCR_WRAP_FLAG_EN
  localparam logic WRAP_BUILT = 1'b1;
`else
  localparam logic WRAP_BUILT = 1'b0;
`endif

  pc_increment_by_4 #(
    .XLEN(32),
    .INCR(32'd4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc(pc),
    .en(en),
    .result(result),
    .carry(carry),
    .misaligned(misaligned),
    .result_q(result_q),
    .valid_q(valid_q),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end else begin
      $display("check %s: observed=%h expected=%h ok", tag, observed, expected);
    end
  endtask

  task automatic push_exp(input string tag, input logic [63:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] observed);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_value("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_value(e.tag, observed, e.value);
    end
  endtask

  // Reference sum as a plain 33-bit addition.
  function automatic logic [32:0] ref_sum(input logic [31:0] p);
    return {1'b0, p} + 33'd4;
  endfunction

  logic [31:0] bnd_pc  [4];
  logic [31:0] bnd_res [4];
  logic        bnd_cry [4];

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [32:0] s;
    bnd_pc[0] = 32'h0000_0000; bnd_res[0] = 32'h0000_0004; bnd_cry[0] = 1'b0;
    bnd_pc[1] = 32'h7FFF_FFFC; bnd_res[1] = 32'h8000_0000; bnd_cry[1] = 1'b0;
    bnd_pc[2] = 32'hFFFF_FFFC; bnd_res[2] = 32'h0000_0000; bnd_cry[2] = 1'b1;
    bnd_pc[3] = 32'hFFFF_FFFF; bnd_res[3] = 32'h0000_0003; bnd_cry[3] = 1'b1;

    rst_n = 1'b1;
    en    = 1'b0;
    pc    = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    check_value("reset_result_q", 64'(result_q), 64'h0);
    check_value("reset_valid_q", 64'(valid_q), 64'h0);
    check_value("reset_wrap", 64'(wrap), 64'h0);

    // Combinational sweep while held in reset: outputs must track pc regardless.
    for (int i = 0; i < 100; i++) begin
      pc = $urandom();
      s  = ref_sum(pc);
      push_exp("sweep_result", 64'(s[31:0]));
      push_exp("sweep_carry", 64'(s[32]));
      push_exp("sweep_misaligned", 64'(pc[1:0] != 2'b00));
      #1;
      pop_check(64'(result));
      pop_check(64'(carry));
      pop_check(64'(misaligned));
    end

    for (int i = 0; i < 4; i++) begin
      pc = bnd_pc[i];
      push_exp($sformatf("boundary_result_%0d", i), 64'(bnd_res[i]));
      push_exp($sformatf("boundary_carry_%0d", i), 64'(bnd_cry[i]));
      #1;
      pop_check(64'(result));
      pop_check(64'(carry));
    end

    pc = 32'h0000_1002;
    push_exp("align_misaligned_1002", 64'h1);
    push_exp("align_result_1002", 64'h1006);
    #1;
    pop_check(64'(misaligned));
    pop_check(64'(result));
    pc = 32'h0000_1000;
    push_exp("align_misaligned_1000", 64'h0);
    #1;
    pop_check(64'(misaligned));
    check_value("still_in_reset_valid_q", 64'(valid_q), 64'h0);

    // Release between edges, capture on the next posedge.
    @(negedge clk);
    rst_n = 1'b1;
    pc    = 32'h100;
    en    = 1'b1;
    push_exp("capture_result_q", 64'h104);
    push_exp("capture_valid_q", 64'h1);
    @(posedge clk); #1;
    pop_check(64'(result_q));
    pop_check(64'(valid_q));

    @(negedge clk);
    en = 1'b0;
    pc = 32'h200;
    push_exp("hold_result_q", 64'h104);
    push_exp("hold_valid_q", 64'h1);
    @(posedge clk); #1;
    pop_check(64'(result_q));
    pop_check(64'(valid_q));

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check_value("async_result_q", 64'(result_q), 64'h0);
    check_value("async_valid_q", 64'(valid_q), 64'h0);
    check_value("async_result_comb", 64'(result), 64'h204);
    @(posedge clk); #1;
    check_value("async_hold_valid_q", 64'(valid_q), 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    pc    = 32'hFFFF_FFFC;
    push_exp("wrap_result_q", 64'h0);
    push_exp("wrap_valid_q", 64'h1);
    push_exp("wrap_set", 64'(WRAP_BUILT));
    @(posedge clk); #1;
    pop_check(64'(result_q));
    pop_check(64'(valid_q));
    pop_check(64'(wrap));

    @(negedge clk);
    pc = 32'h8;
    push_exp("nowrap_result_q", 64'hC);
    push_exp("nowrap_clear", 64'h0);
    @(posedge clk); #1;
    pop_check(64'(result_q));
    pop_check(64'(wrap));

    check_value("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
